// File: rtl/lc3_trace_pkg.sv
// Shared types for the LC3 memory trace buffer: opcode tags, capture FSM states
// and the layout of one stored trace entry.
package lc3_trace_pkg;

    typedef enum logic [3:0] {
        BR   = 4'd0,  ADD = 4'd1,  LD  = 4'd2,  ST  = 4'd3,
        JSR  = 4'd4,  AND = 4'd5,  LDR = 4'd6,  STR = 4'd7,
        RTI  = 4'd8,  NOT = 4'd9,  LDI = 4'd10, STI = 4'd11,
        JMP  = 4'd12, RES = 4'd13, LEA = 4'd14, TRAP = 4'd15
    } lc3_opcode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } trace_state_e;

    // Entry fields are sized for the widest supported configuration; instances
    // zero-extend on write and truncate on read.
    localparam int ENTRY_CH_W   = 8;
    localparam int ENTRY_ADDR_W = 32;
    localparam int ENTRY_DATA_W = 32;

    typedef struct packed {
        logic [ENTRY_CH_W-1:0]   ch;
        logic                    we;
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [ENTRY_DATA_W-1:0] data;
        lc3_opcode_e             opcode;
        logic [15:0]             seq;
    } trace_entry_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] base, input logic [15:0] inc);
        logic [16:0] sum;
        sum = {1'b0, base} + {1'b0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/lc3_trace_fifo.sv
// Show-ahead circular store for trace entries with registered count/full/empty
// and an optional overwrite-oldest mode when a push arrives while full.
module lc3_trace_fifo
    import lc3_trace_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic             overwrite,
    input  trace_entry_t     wr_entry,
    output trace_entry_t     rd_entry,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    // NOTE: entry storage has no reset; pointers and count alone define which
    // slots are valid, so clearing the array would only cost logic.
    trace_entry_t mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             pop_ok, wr_ok, rd_adv;

    // NOTE: every always_comb output is given a default before any branch so
    // that no path leaves it unassigned and infers a latch.
    always_comb begin
        pop_ok   = pop && !empty_q;
        wr_ok    = push && (!full_q || pop_ok || overwrite);
        // A push into a full store without a pop evicts the oldest entry.
        rd_adv   = pop_ok || (wr_ok && full_q);
        wr_ptr_d = wr_ok  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_adv ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({wr_ok, rd_adv})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_ok && !flush) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    assign rd_entry = mem[rd_ptr_q];
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/lc3_mem_trace_buffer.sv
// LC3 memory-access trace buffer: round-robin capture of per-channel accesses,
// opcode tagging, sequence stamping and drop accounting in front of a FIFO.
module lc3_mem_trace_buffer
    import lc3_trace_pkg::*;
#(
    parameter  int NUM_CH       = 2,
    parameter  int ADDR_W       = 16,
    parameter  int DATA_W       = 16,
    parameter  int DEPTH        = 16,
    parameter  int STOP_ON_FULL = 0,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [NUM_CH-1:0]        cap_valid,
    input  logic [NUM_CH-1:0]        cap_we,
    input  logic [NUM_CH*ADDR_W-1:0] cap_addr,
    input  logic [NUM_CH*DATA_W-1:0] cap_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_we,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic [3:0]               out_opcode,
    output logic [15:0]              out_seq,
    output logic [CNT_W-1:0]         count,
    output logic                     full,
    output logic                     empty,
    output logic [15:0]              drop_cnt,
    output logic [1:0]               state
);

    localparam logic OVERWRITE = (STOP_ON_FULL == 0);

    trace_state_e     state_q, state_d;
    logic [15:0]      drop_q, drop_d, seq_q, seq_d;
    lc3_opcode_e      sticky_q, sticky_d;
    logic [CH_W-1:0]  rr_q, rr_d;

    logic             grant_valid;
    logic [CH_W-1:0]  grant_idx, scan_idx;
    logic [15:0]      n_valid, drops;
    logic             push, pop_ok;
    trace_entry_t     wr_entry, rd_entry;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // Round robin: scanning starts at rr_q, the channel after the last grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = rr_q;
        n_valid     = 16'($countones(cap_valid));
        for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_valid && cap_valid[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
            scan_idx = (scan_idx == CH_W'(NUM_CH - 1)) ? '0 : scan_idx + CH_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        drop_d   = drop_q;
        seq_d    = seq_q;
        sticky_d = sticky_q;
        rr_d     = rr_q;
        push     = 1'b0;
        drops    = '0;
        pop_ok   = out_ready && !fifo_empty;

        wr_entry        = '0;
        wr_entry.ch     = ENTRY_CH_W'(grant_idx);
        wr_entry.we     = cap_we[grant_idx];
        wr_entry.addr   = ENTRY_ADDR_W'(cap_addr[grant_idx*ADDR_W +: ADDR_W]);
        wr_entry.data   = ENTRY_DATA_W'(cap_data[grant_idx*DATA_W +: DATA_W]);
        // Only instruction fetches carry an opcode; data accesses inherit the last one.
        wr_entry.opcode = (grant_idx == '0) ? lc3_opcode_e'(cap_data[15:12]) : sticky_q;
        wr_entry.seq    = seq_q;

        if (clear) begin
            state_d  = (state_q == HALTED || !enable) ? IDLE : RUN;
            drop_d   = '0;
            seq_d    = '0;
            sticky_d = BR;
            rr_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) state_d = RUN;
                end
                RUN: begin
                    if (grant_valid) begin
                        if (fifo_full && !pop_ok && STOP_ON_FULL != 0) begin
                            state_d = HALTED;
                            drops   = n_valid;
                        end else begin
                            push  = 1'b1;
                            drops = n_valid - 16'd1 + ((fifo_full && !pop_ok) ? 16'd1 : 16'd0);
                            seq_d = seq_q + 16'd1;
                            rr_d  = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
                            if (grant_idx == '0) sticky_d = wr_entry.opcode;
                        end
                    end
                    if (!enable && state_d == RUN) state_d = IDLE;
                end
                HALTED: begin
                    drops = n_valid;
                end
                default: state_d = IDLE;
            endcase
            drop_d = sat_add16(drop_q, drops);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            drop_q   <= '0;
            seq_q    <= '0;
            sticky_q <= BR;
            rr_q     <= '0;
        end else begin
            state_q  <= state_d;
            drop_q   <= drop_d;
            seq_q    <= seq_d;
            sticky_q <= sticky_d;
            rr_q     <= rr_d;
        end
    end

    lc3_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (clear),
        .push      (push),
        .pop       (out_ready),
        .overwrite (OVERWRITE),
        .wr_entry  (wr_entry),
        .rd_entry  (rd_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign out_ch     = rd_entry.ch[CH_W-1:0];
    assign out_we     = rd_entry.we;
    assign out_addr   = rd_entry.addr[ADDR_W-1:0];
    assign out_data   = rd_entry.data[DATA_W-1:0];
    assign out_opcode = rd_entry.opcode;
    assign out_seq    = rd_entry.seq;
    assign count      = fifo_count;
    assign full       = fifo_full;
    assign empty      = fifo_empty;
    assign drop_cnt   = drop_q;
    assign state      = state_q;

endmodule

// File: tb/tb_lc3_mem_trace_buffer.sv
// Bench for lc3_mem_trace_buffer: an overwrite instance and a stop-on-full
// instance share stimulus and are compared against a queue-based model.
module tb_lc3_mem_trace_buffer;

    logic        clock = 1'b0;
    logic        reset, enable, clear, out_ready;
    logic [1:0]  cap_valid, cap_we;
    logic [31:0] cap_addr, cap_data;

    logic        o_valid [2];
    logic [0:0]  o_ch    [2];
    logic        o_we    [2];
    logic [15:0] o_addr  [2];
    logic [15:0] o_data  [2];
    logic [3:0]  o_op    [2];
    logic [15:0] o_seq   [2];
    logic [4:0]  o_count [2];
    logic        o_full  [2];
    logic        o_empty [2];
    logic [15:0] o_drop  [2];
    logic [1:0]  o_state [2];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lc3_mem_trace_buffer #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16), .DEPTH(16), .STOP_ON_FULL(0)) dut_ovr (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .cap_valid(cap_valid), .cap_we(cap_we), .cap_addr(cap_addr), .cap_data(cap_data),
        .out_valid(o_valid[0]), .out_ready(out_ready), .out_ch(o_ch[0]), .out_we(o_we[0]),
        .out_addr(o_addr[0]), .out_data(o_data[0]), .out_opcode(o_op[0]), .out_seq(o_seq[0]),
        .count(o_count[0]), .full(o_full[0]), .empty(o_empty[0]), .drop_cnt(o_drop[0]),
        .state(o_state[0])
    );

    lc3_mem_trace_buffer #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16), .DEPTH(16), .STOP_ON_FULL(1)) dut_stop (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .cap_valid(cap_valid), .cap_we(cap_we), .cap_addr(cap_addr), .cap_data(cap_data),
        .out_valid(o_valid[1]), .out_ready(out_ready), .out_ch(o_ch[1]), .out_we(o_we[1]),
        .out_addr(o_addr[1]), .out_data(o_data[1]), .out_opcode(o_op[1]), .out_seq(o_seq[1]),
        .count(o_count[1]), .full(o_full[1]), .empty(o_empty[1]), .drop_cnt(o_drop[1]),
        .state(o_state[1])
    );

    // Reference model: index 0 overwrites when full, index 1 halts when full.
    typedef struct {
        int       ch;
        bit       we;
        bit [15:0] addr;
        bit [15:0] data;
        bit [3:0]  op;
        bit [15:0] seq;
    } m_entry_t;

    m_entry_t    m_q [2][$];
    int          m_state  [2];
    int          m_drop   [2];
    bit [15:0]   m_seq    [2];
    bit [3:0]    m_sticky [2];
    int          m_rr     [2];

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit       stop;
            bit       pop;
            bit       full_now;
            int       nv;
            int       drops;
            int       g;
            m_entry_t e;
            stop  = (k == 1);
            pop   = out_ready && (m_q[k].size() > 0);
            nv    = int'(cap_valid[0]) + int'(cap_valid[1]);
            drops = 0;
            if (reset) begin
                m_q[k].delete();
                m_state[k] = 0; m_drop[k] = 0; m_seq[k] = 0; m_sticky[k] = 0; m_rr[k] = 0;
            end else if (clear) begin
                m_q[k].delete();
                m_state[k] = (m_state[k] == 2 || !enable) ? 0 : 1;
                m_drop[k] = 0; m_seq[k] = 0; m_sticky[k] = 0; m_rr[k] = 0;
            end else begin
                if (m_state[k] == 0) begin
                    if (pop) void'(m_q[k].pop_front());
                    if (enable) m_state[k] = 1;
                end else if (m_state[k] == 1) begin
                    full_now = (m_q[k].size() == 16);
                    if (nv > 0) begin
                        if (m_rr[k] == 0) g = cap_valid[0] ? 0 : 1;
                        else              g = cap_valid[1] ? 1 : 0;
                        if (full_now && !pop && stop) begin
                            m_state[k] = 2;
                            drops = nv;
                        end else begin
                            e.ch   = g;
                            e.we   = cap_we[g];
                            e.addr = cap_addr[g*16 +: 16];
                            e.data = cap_data[g*16 +: 16];
                            e.op   = (g == 0) ? cap_data[15:12] : m_sticky[k];
                            e.seq  = m_seq[k];
                            if (pop) void'(m_q[k].pop_front());
                            else if (full_now) begin
                                void'(m_q[k].pop_front());
                                drops = drops + 1;
                            end
                            m_q[k].push_back(e);
                            drops = drops + nv - 1;
                            m_seq[k] = m_seq[k] + 16'd1;
                            m_rr[k] = (g + 1) % 2;
                            if (g == 0) m_sticky[k] = e.op;
                        end
                    end else if (pop) begin
                        void'(m_q[k].pop_front());
                    end
                    if (m_state[k] == 1 && !enable) m_state[k] = 0;
                end else begin
                    drops = nv;
                    if (pop) void'(m_q[k].pop_front());
                end
                m_drop[k] = (m_drop[k] + drops > 65535) ? 65535 : m_drop[k] + drops;
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cap_valid = 2'b00;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; clear = 1'b0; out_ready = 1'b0;
        cap_valid = '0; cap_we = '0; cap_addr = '0; cap_data = '0;
        step(); step();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_state[k] !== 2'd0) begin errors++; $display("FAIL reset_state[%0d]: got %0d expected 0", k, o_state[k]); end
            checks++; if (o_count[k] !== 5'd0) begin errors++; $display("FAIL reset_count[%0d]: got %0d expected 0", k, o_count[k]); end
            checks++; if (o_empty[k] !== 1'b1) begin errors++; $display("FAIL reset_empty[%0d]: got %0b expected 1", k, o_empty[k]); end
            checks++; if (o_full[k] !== 1'b0) begin errors++; $display("FAIL reset_full[%0d]: got %0b expected 0", k, o_full[k]); end
            checks++; if (o_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %0b expected 0", k, o_valid[k]); end
            checks++; if (o_drop[k] !== 16'd0) begin errors++; $display("FAIL reset_drop[%0d]: got %0d expected 0", k, o_drop[k]); end
        end
    endtask

    task automatic test_first_fetch();
        enable = 1'b1;
        step();
        cap_valid = 2'b01; cap_we = 2'b00;
        cap_addr = {16'h0000, 16'h3000}; cap_data = {16'h0000, 16'h1261};
        step();
        cap_valid = 2'b00;
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_valid[k] !== 1'b1) begin errors++; $display("FAIL fetch_out_valid[%0d]: got %0b expected 1", k, o_valid[k]); end
            checks++; if (o_op[k] !== 4'd1) begin errors++; $display("FAIL fetch_opcode[%0d]: got %0d expected 1", k, o_op[k]); end
            checks++; if (o_seq[k] !== 16'd0) begin errors++; $display("FAIL fetch_seq[%0d]: got %0d expected 0", k, o_seq[k]); end
            checks++; if (o_count[k] !== 5'd1) begin errors++; $display("FAIL fetch_count[%0d]: got %0d expected 1", k, o_count[k]); end
            checks++; if (o_addr[k] !== 16'h3000) begin errors++; $display("FAIL fetch_addr[%0d]: got %h expected 3000", k, o_addr[k]); end
        end
    endtask

    task automatic test_round_robin();
        do_clear();
        cap_valid = 2'b11; cap_we = 2'b10;
        cap_addr = {16'h4001, 16'h3001}; cap_data = {16'hA0F0, 16'h5ABC};
        step(); step();
        cap_valid = 2'b00;
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_count[k] !== 5'd2) begin errors++; $display("FAIL rr_count[%0d]: got %0d expected 2", k, o_count[k]); end
            checks++; if (o_drop[k] !== 16'd2) begin errors++; $display("FAIL rr_drop[%0d]: got %0d expected 2", k, o_drop[k]); end
            checks++; if (o_ch[k] !== 1'b0) begin errors++; $display("FAIL rr_first_ch[%0d]: got %0d expected 0", k, o_ch[k]); end
            checks++; if (o_op[k] !== 4'd5) begin errors++; $display("FAIL rr_first_op[%0d]: got %0d expected 5", k, o_op[k]); end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_ch[k] !== 1'b1) begin errors++; $display("FAIL rr_second_ch[%0d]: got %0d expected 1", k, o_ch[k]); end
            checks++; if (o_op[k] !== 4'd5) begin errors++; $display("FAIL rr_second_op[%0d]: got %0d expected 5", k, o_op[k]); end
            checks++; if (o_seq[k] !== 16'd1) begin errors++; $display("FAIL rr_second_seq[%0d]: got %0d expected 1", k, o_seq[k]); end
            checks++; if (o_addr[k] !== 16'h4001) begin errors++; $display("FAIL rr_second_addr[%0d]: got %h expected 4001", k, o_addr[k]); end
        end
    endtask

    task automatic test_full_policies();
        do_clear();
        for (int i = 0; i < 17; i++) begin
            cap_valid = 2'b01; cap_we = 2'($urandom_range(0, 3));
            cap_addr = $urandom; cap_data = $urandom;
            step();
        end
        cap_valid = 2'b00;
        checks++; if (o_count[0] !== 5'd16) begin errors++; $display("FAIL ovr_count: got %0d expected 16", o_count[0]); end
        checks++; if (o_seq[0] !== 16'd1) begin errors++; $display("FAIL ovr_head_seq: got %0d expected 1", o_seq[0]); end
        checks++; if (o_drop[0] !== 16'd1) begin errors++; $display("FAIL ovr_drop: got %0d expected 1", o_drop[0]); end
        checks++; if (o_state[0] !== 2'd1) begin errors++; $display("FAIL ovr_state: got %0d expected 1", o_state[0]); end
        checks++; if (o_state[1] !== 2'd2) begin errors++; $display("FAIL stop_state: got %0d expected 2", o_state[1]); end
        checks++; if (o_seq[1] !== 16'd0) begin errors++; $display("FAIL stop_head_seq: got %0d expected 0", o_seq[1]); end
        checks++; if (o_drop[1] !== 16'd1) begin errors++; $display("FAIL stop_drop: got %0d expected 1", o_drop[1]); end
        checks++; if (o_full[1] !== 1'b1) begin errors++; $display("FAIL stop_full: got %0b expected 1", o_full[1]); end
        do_clear();
        checks++; if (o_state[1] !== 2'd0) begin errors++; $display("FAIL stop_clear_state: got %0d expected 0", o_state[1]); end
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_empty[k] !== 1'b1) begin errors++; $display("FAIL clear_empty[%0d]: got %0b expected 1", k, o_empty[k]); end
            checks++; if (o_drop[k] !== 16'd0) begin errors++; $display("FAIL clear_drop[%0d]: got %0d expected 0", k, o_drop[k]); end
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        step();
        for (int i = 0; i < 16; i++) begin
            cap_valid = 2'b01; cap_addr = $urandom; cap_data = $urandom;
            step();
        end
        cap_valid = 2'b01; out_ready = 1'b1; cap_data = $urandom;
        step();
        cap_valid = 2'b00; out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_count[k] !== 5'd16) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 16", k, o_count[k]); end
            checks++; if (o_drop[k] !== 16'd0) begin errors++; $display("FAIL b2b_drop[%0d]: got %0d expected 0", k, o_drop[k]); end
            checks++; if (o_seq[k] !== 16'd1) begin errors++; $display("FAIL b2b_head_seq[%0d]: got %0d expected 1", k, o_seq[k]); end
            checks++; if (o_state[k] !== 2'd1) begin errors++; $display("FAIL b2b_state[%0d]: got %0d expected 1", k, o_state[k]); end
        end
    endtask

    task automatic test_sticky_and_reset();
        do_clear();
        cap_valid = 2'b01; cap_we = 2'b00; cap_addr = {16'h0, 16'h3100}; cap_data = {16'h0, 16'h6ABC};
        step();
        cap_valid = 2'b10; cap_we = 2'b10; cap_addr = {16'h5000, 16'h0}; cap_data = {16'h2345, 16'h0};
        step();
        cap_valid = 2'b00; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_ch[k] !== 1'b1) begin errors++; $display("FAIL sticky_ch[%0d]: got %0d expected 1", k, o_ch[k]); end
            checks++; if (o_op[k] !== 4'd6) begin errors++; $display("FAIL sticky_op[%0d]: got %0d expected 6", k, o_op[k]); end
            checks++; if (o_we[k] !== 1'b1) begin errors++; $display("FAIL sticky_we[%0d]: got %0b expected 1", k, o_we[k]); end
            checks++; if (o_data[k] !== 16'h2345) begin errors++; $display("FAIL sticky_data[%0d]: got %h expected 2345", k, o_data[k]); end
        end
        for (int i = 0; i < 3; i++) begin
            cap_valid = 2'b11; cap_data = $urandom; cap_addr = $urandom;
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0; cap_valid = 2'b00;
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_empty[k] !== 1'b1) begin errors++; $display("FAIL midreset_empty[%0d]: got %0b expected 1", k, o_empty[k]); end
            checks++; if (o_valid[k] !== 1'b0) begin errors++; $display("FAIL midreset_valid[%0d]: got %0b expected 0", k, o_valid[k]); end
            checks++; if (o_state[k] !== 2'd0) begin errors++; $display("FAIL midreset_state[%0d]: got %0d expected 0", k, o_state[k]); end
        end
    endtask

    task automatic test_random();
        int ready_pct;
        for (int cyc = 0; cyc < 800; cyc++) begin
            ready_pct = ((cyc / 100) % 2 == 0) ? 15 : 70;
            enable    = ($urandom_range(0, 19) != 0);
            clear     = ($urandom_range(0, 149) == 0);
            cap_valid = 2'($urandom_range(0, 3));
            cap_we    = 2'($urandom_range(0, 3));
            cap_addr  = $urandom;
            cap_data  = $urandom;
            out_ready = ($urandom_range(0, 99) < ready_pct);
            step();
            for (int k = 0; k < 2; k++) begin
                checks++; if (o_state[k] !== 2'(m_state[k])) begin errors++; $display("FAIL rnd_state[%0d] cyc %0d: got %0d expected %0d", k, cyc, o_state[k], m_state[k]); end
                checks++; if (o_count[k] !== 5'(m_q[k].size())) begin errors++; $display("FAIL rnd_count[%0d] cyc %0d: got %0d expected %0d", k, cyc, o_count[k], m_q[k].size()); end
                checks++; if (o_full[k] !== (m_q[k].size() == 16)) begin errors++; $display("FAIL rnd_full[%0d] cyc %0d: got %0b", k, cyc, o_full[k]); end
                checks++; if (o_empty[k] !== (m_q[k].size() == 0)) begin errors++; $display("FAIL rnd_empty[%0d] cyc %0d: got %0b", k, cyc, o_empty[k]); end
                checks++; if (o_valid[k] !== (m_q[k].size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] cyc %0d: got %0b", k, cyc, o_valid[k]); end
                checks++; if (o_drop[k] !== 16'(m_drop[k])) begin errors++; $display("FAIL rnd_drop[%0d] cyc %0d: got %0d expected %0d", k, cyc, o_drop[k], m_drop[k]); end
                if (m_q[k].size() != 0) begin
                    checks++;
                    if (o_ch[k] !== 1'(m_q[k][0].ch) || o_we[k] !== m_q[k][0].we ||
                        o_addr[k] !== m_q[k][0].addr || o_data[k] !== m_q[k][0].data ||
                        o_op[k] !== m_q[k][0].op || o_seq[k] !== m_q[k][0].seq) begin
                        errors++;
                        $display("FAIL rnd_head[%0d] cyc %0d: got ch%0d we%0b %h %h op%0d seq%0d expected ch%0d we%0b %h %h op%0d seq%0d",
                                 k, cyc, o_ch[k], o_we[k], o_addr[k], o_data[k], o_op[k], o_seq[k],
                                 m_q[k][0].ch, m_q[k][0].we, m_q[k][0].addr, m_q[k][0].data, m_q[k][0].op, m_q[k][0].seq);
                    end
                end
            end
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_round_robin();
        test_full_policies();
        test_back_to_back();
        test_sticky_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_mem_trace_buffer.md
LC3_MEM_TRACE_BUFFER -- requirements
Module: lc3_mem_trace_buffer

Interface
REQ-001 Parameter NUM_CH, default 2, number of capture channels (>=1); channel 0 is instruction fetch.
REQ-002 Parameter ADDR_W, default 16, memory address width.
REQ-003 Parameter DATA_W, default 16, memory data width (>=16).
REQ-004 Parameter DEPTH, default 16, trace entries; power of 2, >=2.
REQ-005 Parameter STOP_ON_FULL, default 0; 1 = halt capture when full, 0 = overwrite oldest entry.
REQ-006 clock  in  1  sole clock; all logic rising-edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 enable  in  1  capture enable.
REQ-009 clear  in  1  synchronous flush of buffer, counters and halt.
REQ-010 cap_valid  in  NUM_CH  per-channel memory access strobe.
REQ-011 cap_we  in  NUM_CH  per-channel write flag (1 = store).
REQ-012 cap_addr  in  NUM_CH*ADDR_W  packed addresses; channel k at [k*ADDR_W +: ADDR_W].
REQ-013 cap_data  in  NUM_CH*DATA_W  packed data, same packing.
REQ-014 out_valid  out  1  head entry present.
REQ-015 out_ready  in  1  consumer pops head when out_valid & out_ready.
REQ-016 out_ch  out  max(1,$clog2(NUM_CH))  source channel of head.
REQ-017 out_we / out_addr / out_data  out  1 / ADDR_W / DATA_W  head access fields.
REQ-018 out_opcode  out  4  LC3 opcode tag of head.
REQ-019 out_seq  out  16  sequence stamp of head.
REQ-020 count  out  $clog2(DEPTH)+1  entries held; full / empty  out  1 each.
REQ-021 drop_cnt  out  16  lost captures; state  out  2  FSM state.

Function
REQ-022 FSM states IDLE, RUN, HALTED: IDLE->RUN when enable=1; RUN->IDLE when enable=0; RUN->HALTED when STOP_ON_FULL=1 and a capture is attempted while full (pop not asserted that cycle); HALTED->IDLE on clear (no capture that cycle).
REQ-023 Capture only in RUN; among asserted cap_valid, a round-robin arbiter grants one channel per cycle, starting after the last granted channel.
REQ-024 Each ungranted asserted cap_valid in RUN, and every asserted cap_valid in HALTED, increments drop_cnt by one; IDLE requests are ignored and not counted.
REQ-025 drop_cnt saturates at 16'hFFFF; multiple drops in one cycle add together, clamped.
REQ-026 Tag: granted channel 0 gets opcode = cap_data[15:12] and loads the sticky last-opcode register; other channels get the sticky value held before that edge.
REQ-027 out_seq of an entry = 16-bit capture counter value at capture; counter increments per accepted entry, wraps FFFF->0000.
REQ-028 Show-ahead head: entry captured at edge N visible on out_* after edge N; out_valid = !empty; pop when empty is ignored.
REQ-029 Full without pop: STOP_ON_FULL=0 -> write new entry, discard oldest, drop_cnt+1, count stays DEPTH; STOP_ON_FULL=1 -> per REQ-022, entry dropped and counted.
REQ-030 Full with simultaneous pop and push: both occur, no drop, count stays DEPTH, no halt.
REQ-031 Empty with simultaneous push and pop: pop ignored, count becomes 1.
REQ-032 Pointers wrap modulo DEPTH; count/full/empty registered and consistent every cycle.
REQ-033 Priority: reset > clear > push/pop; clear empties buffer, zeroes drop_cnt, seq counter, sticky opcode, arbiter pointer; same-cycle captures discarded, not counted.

Reset
REQ-034 On reset: state IDLE, count 0, empty 1, full 0, out_valid 0, drop_cnt 0, seq counter 0, sticky opcode BR (0), arbiter pointer 0, pointers 0.
REQ-035 Reset mid-operation discards all entries; out_* data fields are don't-care while out_valid=0.

Structure
REQ-036 Package lc3_trace_pkg holds the 4-bit LC3 opcode enum (BR=0 ... TRAP=15), the 2-bit state enum (IDLE=0, RUN=1, HALTED=2), and the entry struct {ch, we, addr, data, opcode, seq}.
REQ-037 Storage, pointers and count in one sub-module lc3_trace_fifo (push, pop, overwrite inputs); arbiter, tagging, FSM and counters in the top.

Verification
REQ-038 Reset, enable=1, ch0 fetch addr 16'h3000 data 16'h1261 -> next cycle out_valid=1, out_opcode=1 (ADD), out_seq=0, count=1.
REQ-039 ch0 and ch1 valid same cycle, twice -> first grant ch0, second ch1 (round robin), drop_cnt=2.
REQ-040 STOP_ON_FULL=0, DEPTH=16, 17 ch0 captures, no pop -> count=16, head out_seq=1, drop_cnt=1, state RUN.
REQ-041 STOP_ON_FULL=1, 17 captures -> state HALTED, head out_seq=0, drop_cnt=1; then clear -> IDLE, empty=1, drop_cnt=0.
REQ-042 Full buffer with push and out_ready same cycle -> count stays 16, drop_cnt unchanged, head advances by one.
REQ-043 ch0 data 16'h6xxx (LDR) then ch1 load -> ch1 entry out_opcode=6; reset asserted mid-burst -> empty=1 next cycle.
